// File: rtl/mode_power_pkg.sv
// ============================================================================
//  Module   : mode_power_pkg
//  Purpose  : Shared types and constants for the mode_power block:
//             FSM state encoding, chs_conf field positions, ramp-rate to
//             period encoding and the optional power cap value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mode_power_pkg;

  // Bit 1 of the encoding is the "ramping" flag, so chs_busy can be taken
  // straight from a state flop with no decode logic behind it.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    HOLD      = 2'b01,
    RAMP_UP   = 2'b10,
    RAMP_DOWN = 2'b11
  } state_t;

  // chs_conf field positions
  localparam int c_conf_mode_bit = 7;
  localparam int c_conf_en_bit   = 6;
  localparam int c_conf_rate_hi  = 5;
  localparam int c_conf_rate_lo  = 4;
  localparam int c_conf_tgt_hi   = 3;
  localparam int c_conf_tgt_lo   = 0;

  // Largest effective target when the power cap is compiled in
  localparam logic [3:0] c_power_cap = 4'd12;

  // Ramp rate 00/01/10/11 -> period of 1/2/4/8 cycles
  function automatic logic [3:0] rate_to_period(input logic [1:0] rate);
    return 4'd1 << rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mode_power_prescaler.sv
// ============================================================================
//  Module   : mode_power_prescaler
//  Purpose  : Ramp prescaler. Counts while i_run is high and produces a
//             one-cycle o_step pulse once per ramp period; the count wraps
//             to 0 after each step and is held at 0 while i_run is low.
//  Ports    : clk     - rising-edge clock
//             rst_n   - asynchronous active-low reset
//             i_rate  - ramp rate code (period 1/2/4/8 cycles)
//             i_run   - count enable (power differs from target)
//             o_step  - single-cycle step request
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mode_power_prescaler
  import mode_power_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_rate,
  input  logic       i_run,
  output logic       o_step
);

  logic [2:0] r_cnt;
  logic [3:0] w_last;

  assign w_last = rate_to_period(i_rate) - 4'd1;

  // ">=" rather than "==" so that lowering the rate while the count is
  // already beyond the new terminal value still steps at once instead of
  // running on until the 3-bit counter wraps.
  assign o_step = i_run && ({1'b0, r_cnt} >= w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
    end else if (!i_run || o_step) begin
      r_cnt <= 3'd0;
    end else begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mode_power.sv
// ============================================================================
//  Module   : mode_power
//  Purpose  : Applied power level controller. Samples chs_conf every clock
//             and either jumps straight to the effective target (direct
//             mode) or ramps one step at a time toward it (ramped mode).
//  Ports    : clk       - rising-edge clock
//             rst_n     - asynchronous active-low reset
//             chs_conf  - [7] mode, [6] enable, [5:4] rate, [3:0] target
//             chs_power - registered applied power level 0..15
//             chs_mode  - registered mode (0 direct, 1 ramped)
//             chs_busy  - registered, high while power differs from target
//  Config   : MODE_POWER_CAP_EN - when defined, clamp effective target to 12
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mode_power
  import mode_power_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] chs_conf,
  output logic [3:0] chs_power,
  output logic       chs_mode,
  output logic       chs_busy
);

  logic       w_mode;
  logic       w_enable;
  logic [1:0] w_rate;
  logic [3:0] w_target_raw;
  logic [3:0] w_target;
  logic       w_run;
  logic       w_step;
  logic [3:0] w_power_nxt;
  state_t     w_state_nxt;

  logic [3:0] r_power;
  logic       r_mode;
  state_t     r_state;

  assign w_mode       = chs_conf[c_conf_mode_bit];
  assign w_enable     = chs_conf[c_conf_en_bit];
  assign w_rate       = chs_conf[c_conf_rate_hi:c_conf_rate_lo];
  assign w_target_raw = w_enable ? chs_conf[c_conf_tgt_hi:c_conf_tgt_lo] : 4'd0;

`ifdef MODE_POWER_CAP_EN
  assign w_target = (w_target_raw > c_power_cap) ? c_power_cap : w_target_raw;
`else
  assign w_target = w_target_raw;
`endif

  // Only ramped mode uses the prescaler; in direct mode it stays parked at 0
  // so a later switch to ramped mode starts a fresh period.
  assign w_run = w_mode && (r_power != w_target);

  mode_power_prescaler u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rate (w_rate),
    .i_run  (w_run),
    .o_step (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_power <= 4'd0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_power <= w_power_nxt;
      r_mode  <= w_mode;
    end
  end

  always_comb begin
    w_power_nxt = r_power;
    w_state_nxt = r_state;

    // Direction is decided from the current target each step, so a target
    // change mid-ramp redirects the very next step.
    if (!w_mode) begin
      w_power_nxt = w_target;
    end else if (w_step) begin
      if ((r_power < w_target) && (r_power != 4'hF)) begin
        w_power_nxt = r_power + 4'd1;
      end else if ((r_power > w_target) && (r_power != 4'h0)) begin
        w_power_nxt = r_power - 4'd1;
      end
    end

    // State tracks the relation between the power being loaded and the
    // target, so it (and chs_busy) line up with the registered chs_power.
    if (w_power_nxt == w_target) begin
      w_state_nxt = (w_target == 4'd0) ? IDLE : HOLD;
    end else if (w_power_nxt < w_target) begin
      w_state_nxt = RAMP_UP;
    end else begin
      w_state_nxt = RAMP_DOWN;
    end
  end

  assign chs_power = r_power;
  assign chs_mode  = r_mode;
  assign chs_busy  = r_state[1];

endmodule

`default_nettype wire

// File: tb/tb_mode_power.sv
// ============================================================================
//  Module   : tb_mode_power
//  Purpose  : Self-checking testbench for mode_power using directed vector
//             tables plus hand-written multi-cycle ramp sequences.
//  Config   : MODE_POWER_CAP_EN - selects the expected capped level
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mode_power;

  typedef struct {
    logic [7:0] conf;
    logic [3:0] power;
    logic       mode;
    logic       busy;
  } vec_t;

`ifdef MODE_POWER_CAP_EN
  localparam logic [3:0] CAP = 4'd12;
`else
  localparam logic [3:0] CAP = 4'd15;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] chs_conf;
  logic [3:0] chs_power;
  logic       chs_mode;
  logic       chs_busy;

  int checks;
  int failures;
  vec_t vq[$];

  mode_power dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .chs_conf  (chs_conf),
    .chs_power (chs_power),
    .chs_mode  (chs_mode),
    .chs_busy  (chs_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] ep, input logic em,
                       input logic eb);
    checks++;
    if (chs_power !== ep || chs_mode !== em || chs_busy !== eb) begin
      failures++;
      $display("FAIL %s: got power=%0d mode=%0b busy=%0b, expected power=%0d mode=%0b busy=%0b",
               name, chs_power, chs_mode, chs_busy, ep, em, eb);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic [7:0] conf);
    @(negedge clk);
    chs_conf = conf;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] c, input logic [3:0] p, input logic m,
                     input logic b);
    vec_t v;
    v.conf = c; v.power = p; v.mode = m; v.busy = b;
    vq.push_back(v);
  endtask

  task automatic run_table(input string tag);
    int n;
    n = vq.size();
    for (int i = 0; i < n; i++) begin
      apply(vq[i].conf);
      check($sformatf("%s[%0d] conf=%02h", tag, i, vq[i].conf),
            vq[i].power, vq[i].mode, vq[i].busy);
    end
    vq.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    chs_conf = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state, direct mode
    add(8'h00, 4'd0, 1'b0, 1'b0);
    add(8'h68, 4'd8, 1'b0, 1'b0);
    add(8'h68, 4'd8, 1'b0, 1'b0);
    run_table("direct");

    // Ramped, enable off, rate 01: down one step per 2 cycles from 8
    for (int k = 1; k <= 16; k++) begin
      apply(8'h96);
      check($sformatf("ramp_down_r01 k=%0d", k), 4'(8 - k / 2), 1'b1, (k < 16));
    end

    add(8'h47, 4'd7, 1'b0, 1'b0);
    add(8'h40, 4'd0, 1'b0, 1'b0);
    run_table("direct2");

    // Ramped rate 00: 1..7 on consecutive cycles
    for (int k = 1; k <= 7; k++) begin
      apply(8'hC7);
      check($sformatf("ramp_up_r00 k=%0d", k), 4'(k), 1'b1, (k != 7));
    end

    // Redirect mid-ramp, mode switches in both directions
    add(8'h40, 4'd0, 1'b0, 1'b0);
    add(8'hC7, 4'd1, 1'b1, 1'b1);
    add(8'hC7, 4'd2, 1'b1, 1'b1);
    add(8'hC7, 4'd3, 1'b1, 1'b1);
    add(8'hC7, 4'd4, 1'b1, 1'b1);
    add(8'hC2, 4'd3, 1'b1, 1'b1);
    add(8'hC2, 4'd2, 1'b1, 1'b0);
    add(8'hD7, 4'd2, 1'b1, 1'b1);
    add(8'hD7, 4'd3, 1'b1, 1'b1);
    add(8'h57, 4'd7, 1'b0, 1'b0);
    add(8'hC0, 4'd6, 1'b1, 1'b1);
    run_table("redirect");

    // Rate 11: one step after 8 cycles
    for (int k = 1; k <= 8; k++) begin
      apply(8'hF0);
      check($sformatf("ramp_r11 k=%0d", k), (k == 8) ? 4'd5 : 4'd6, 1'b1, 1'b1);
    end

    // Power cap
    add(8'h4F, CAP, 1'b0, 1'b0);
    add(8'hCF, CAP, 1'b1, 1'b0);
    add(8'hC0, CAP - 4'd1, 1'b1, 1'b1);
    run_table("cap");

    // Asynchronous reset mid-ramp: outputs clear with no clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chs_conf = 8'h45;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_first_edge", 4'd5, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mode_power.md
MODE_POWER -- requirements
Module: mode_power

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 chs_conf  input  8  configuration word, sampled every rising clk edge.
REQ-005 chs_power  output  4  registered applied power level, 0..15.
REQ-006 chs_mode  output  1  registered operating mode: 0 = direct, 1 = ramped.
REQ-007 chs_busy  output  1  registered; high while chs_power differs from the effective target.

Function
REQ-008 chs_conf fields SHALL be:
- [7] mode
- [6] enable
- [5:4] ramp rate
- [3:0] target power
REQ-009 Effective target SHALL be chs_conf[3:0] when enable=1, else 0.
REQ-010 chs_mode SHALL equal chs_conf[7] sampled on the previous edge (1-cycle latency).
REQ-011 In direct mode (sampled [7]=0), chs_power SHALL equal the effective target one cycle after sampling; chs_busy SHALL be 0.
REQ-012 In ramped mode, chs_power SHALL step by exactly +1 or -1 toward the effective target once per ramp period.
REQ-013 The ramp period SHALL be 1, 2, 4 or 8 cycles for rate 00, 01, 10 and 11.
REQ-014 The prescaler SHALL count while chs_power != target and hold at 0 when equal; a step SHALL occur when the count reaches period-1, then the count wraps to 0.
REQ-015 The state machine SHALL have four states with these transitions:
- IDLE: power 0 and target 0.
- HOLD: power = target != 0.
- RAMP_UP: power < target.
- RAMP_DOWN: power > target.
- Transitions SHALL be evaluated every cycle from the current power and target.
REQ-016 A target change mid-ramp SHALL redirect the next step toward the new target, without resetting the prescaler.
REQ-017 Switching mode 1->0 mid-ramp SHALL set chs_power to the target on the next cycle.
REQ-018 Switching mode 0->1 SHALL start ramping from the present chs_power.
REQ-019 chs_power SHALL never wrap: no step occurs at 0 downward or at 15 upward.
REQ-020 chs_busy SHALL be high exactly in the RAMP_UP and RAMP_DOWN states.

Reset
REQ-021 While rst_n=0, the block SHALL hold:
- chs_power=0
- chs_mode=0
- chs_busy=0
- state IDLE
- prescaler 0
REQ-022 Reset assertion mid-ramp SHALL abort the ramp immediately, without waiting for a clock edge.
REQ-023 After reset release, the first edge SHALL sample chs_conf normally.

Configuration
REQ-024 The power cap SHALL be compiled in or out by the macro MODE_POWER_CAP_EN.
- Defined: the effective target SHALL be clamped to at most 12.
- Undefined: targets up to 15 SHALL be passed unchanged.

Structure
REQ-025 Package mode_power_pkg SHALL hold:
- the state enum (IDLE, RAMP_UP, RAMP_DOWN, HOLD)
- chs_conf field bit positions
- rate-to-period encoding
- the cap constant 12
REQ-026 The ramp prescaler SHALL be the sub-module mode_power_prescaler.
- Inputs: rate, run.
- Output: 1-cycle step pulse.

Verification
REQ-027 Reset, then chs_conf=0x00 -> chs_power=0, chs_mode=0, chs_busy=0.
REQ-028 Direct mode: chs_conf=0x68 (mode0, en1, rate10, target 8) -> chs_power=8 one cycle later, chs_busy=0.
REQ-029 Ramped, enable off:
- chs_conf=0x96 (mode1, en0, target 6) from power 8 -> steps down 1 per 2 cycles.
- chs_power reaches 0 after 16 cycles, then chs_busy=0.
REQ-030 Ramped: chs_conf=0xC7 (mode1, en1, rate00, target 7) from 0 -> chs_power 1..7 on consecutive cycles, chs_busy low once at 7.
REQ-031 Redirect mid-ramp: at power 4 while ramping to 7, set target 2 -> next step gives power 3.
REQ-032 Reset mid-ramp: assert rst_n=0 -> all outputs 0 immediately.
REQ-033 Cap: chs_conf=0x4F with MODE_POWER_CAP_EN -> chs_power=12; without it -> chs_power=15.
